// File: rtl/chatbot_responder_if.sv
// UART-side parallel bus for chatbot_responder: receive strobe/data in, transmit handshake out.
// master = UART/host side, slave = responder.
interface chatbot_responder_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_done;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       busy;
    logic [1:0] resp_code;

    modport master (
        output rx_byte, rx_valid, tx_done,
        input  tx_byte, tx_load, busy, resp_code
    );

    modport slave (
        input  rx_byte, rx_valid, tx_done,
        output tx_byte, tx_load, busy, resp_code
    );
endinterface

// File: rtl/chatbot_responder.sv
// Line-oriented command responder: buffers a line up to CR, answers HI/PING/other with HELLO/PONG/ERR.
// Optional macro CHATBOT_ECHO_EN echoes every byte received while idle before processing it.
module chatbot_responder #(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    chatbot_responder_if.slave bus
);
    localparam int         BUF_D     = (MAX_LEN < 4) ? 4 : MAX_LEN;
    localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [55:0] STR_HELLO = {"HELLO", 8'h0D, 8'h0A};
    localparam logic [47:0] STR_PONG  = {"PONG", 8'h0D, 8'h0A};
    localparam logic [39:0] STR_ERR   = {"ERR", 8'h0D, 8'h0A};

    typedef enum logic [2:0] {
        S_IDLE, S_MATCH, S_LOAD, S_WAIT
`ifdef CHATBOT_ECHO_EN
        , S_ECHO_LOAD, S_ECHO_WAIT
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic       ovf_q, ovf_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] code_q, code_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       rx_valid_q, tx_done_q;
    logic       rx_evt, done_evt, is_print, store;
    logic       is_hi, is_ping;
    logic [1:0] match_code;
    logic [7:0] line_q [BUF_D];

    function automatic logic [7:0] rom_char(input logic [1:0] code, input logic [2:0] idx);
        logic [7:0] c;
        case (code)
            2'd1:    c = STR_HELLO[8*(6 - int'(idx)) +: 8];
            2'd2:    c = STR_PONG[8*(5 - int'(idx)) +: 8];
            2'd3:    c = STR_ERR[8*(4 - int'(idx)) +: 8];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] rom_last(input logic [1:0] code);
        logic [2:0] l;
        case (code)
            2'd1:    l = 3'd6;
            2'd2:    l = 3'd5;
            default: l = 3'd4;
        endcase
        return l;
    endfunction

    assign rx_evt   = bus.rx_valid & ~rx_valid_q;
    assign done_evt = bus.tx_done & ~tx_done_q;
    assign is_print = (bus.rx_byte >= 8'h20) && (bus.rx_byte <= 8'h7E);
    assign store    = (state_q == S_IDLE) && rx_evt && is_print && (len_q < MAX_LEN_W);

    // Cells past MAX_LEN exist only so the 4-character PING compare always has operands.
    for (genvar gi = 0; gi < BUF_D; gi++) begin : g_line
        if (gi < MAX_LEN) begin : g_cell
            logic [7:0] ch_q;
            always_ff @(posedge clk) begin
                if (reset)
                    ch_q <= 8'h00;
                else if (store && len_q == 4'(gi))
                    ch_q <= bus.rx_byte;
            end
            assign line_q[gi] = ch_q;
        end else begin : g_pad
            assign line_q[gi] = 8'h00;
        end
    end

    assign is_hi   = !ovf_q && len_q == 4'd2 && line_q[0] == "H" && line_q[1] == "I";
    assign is_ping = !ovf_q && len_q == 4'd4 && line_q[0] == "P" && line_q[1] == "I"
                     && line_q[2] == "N" && line_q[3] == "G";
    assign match_code = is_hi ? 2'd1 : (is_ping ? 2'd2 : 2'd3);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        code_d    = code_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if (rx_evt) begin
`ifdef CHATBOT_ECHO_EN
                    tx_byte_d = bus.rx_byte;
                    state_d   = S_ECHO_LOAD;
`else
                    if (bus.rx_byte == CR && len_q != 4'd0)
                        state_d = S_MATCH;
`endif
                    if (is_print) begin
                        if (len_q < MAX_LEN_W) len_d = len_q + 4'd1;
                        else                   ovf_d = 1'b1;
                    end
                end
            end
            S_MATCH: begin
                code_d    = match_code;
                idx_d     = 3'd0;
                tx_byte_d = rom_char(match_code, 3'd0);
                state_d   = S_LOAD;
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                // Only a fresh rising edge of tx_done advances; a level already high is ignored.
                if (done_evt) begin
                    if (idx_q == rom_last(code_q)) begin
                        len_d   = 4'd0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_byte_d = rom_char(code_q, idx_q + 3'd1);
                        state_d   = S_LOAD;
                    end
                end
            end
`ifdef CHATBOT_ECHO_EN
            S_ECHO_LOAD: state_d = S_ECHO_WAIT;
            S_ECHO_WAIT: begin
                if (done_evt)
                    state_d = (tx_byte_q == CR && len_q != 4'd0) ? S_MATCH : S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rx_valid_q <= bus.rx_valid;
        tx_done_q  <= bus.tx_done;
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= 4'd0;
            ovf_q     <= 1'b0;
            idx_q     <= 3'd0;
            code_q    <= 2'd0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            tx_byte_q <= tx_byte_d;
        end
    end

`ifdef CHATBOT_ECHO_EN
    assign bus.tx_load = (state_q == S_LOAD) || (state_q == S_ECHO_LOAD);
`else
    assign bus.tx_load = (state_q == S_LOAD);
`endif
    assign bus.tx_byte   = tx_byte_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.resp_code = code_q;
endmodule

// File: tb/tb_chatbot_responder.sv
// Directed bench for chatbot_responder: a UART model answers each tx_load with a tx_done edge.
// Expected streams account for echo bytes when CHATBOT_ECHO_EN is defined.
module tb_chatbot_responder;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic clk = 1'b0;
    logic reset;
    chatbot_responder_if bus();

    chatbot_responder #(.MAX_LEN(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];
    int load_cyc_q[$];
    int done_cyc_q[$];
    int rx_cyc_q[$];
    int busy_fall_cyc = -1;
    bit hold_mode = 1'b0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model: normally drops tx_done on load and raises it 20 cycles later;
    // in hold_mode tx_done stays high through the load and pulses low/high later.
    initial begin
        bus.tx_done = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_load === 1'b1) begin
                byte_q.push_back(bus.tx_byte);
                load_cyc_q.push_back(cyc);
                $display("cycle %0d: tx_load byte=%02h", cyc, bus.tx_byte);
                if (hold_mode) begin
                    repeat (10) @(posedge clk);
                    #1; bus.tx_done = 1'b0;
                    @(posedge clk);
                    #1; bus.tx_done = 1'b1;
                end else begin
                    bus.tx_done = 1'b0;
                    repeat (20) @(posedge clk);
                    #1; bus.tx_done = 1'b1;
                end
                done_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (busy_prev && bus.busy === 1'b0) busy_fall_cyc = cyc;
            busy_prev = bus.busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        byte_q.delete();
        exp_q.delete();
        load_cyc_q.delete();
        done_cyc_q.delete();
        rx_cyc_q.delete();
        busy_fall_cyc = -1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 500) begin
            @(posedge clk); #2;
            k++;
        end
        total++;
        if (k >= 500) begin
            bad++;
            $display("FAIL idle_timeout: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
`ifdef CHATBOT_ECHO_EN
        if (bus.busy === 1'b0) exp_q.push_back(b);
`endif
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        rx_cyc_q.push_back(cyc);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
`ifdef CHATBOT_ECHO_EN
        if (b != CR) wait_idle();
`endif
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (!(byte_q.size() >= n && bus.busy === 1'b0) && k < 3000) begin
            @(posedge clk); #2;
            k++;
        end
        total++;
        if (k >= 3000) begin
            bad++;
            $display("FAIL resp_timeout: got %0d bytes want %0d", byte_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.tx_load !== 1'b0) begin bad++; $display("FAIL reset_tx_load: got %b want 0", bus.tx_load); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.resp_code !== 2'd0) begin bad++; $display("FAIL reset_resp_code: got %0d want 0", bus.resp_code); end
        total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %02h want 00", bus.tx_byte); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_hello();
        int cr_cyc;
        int f;
        clear_logs();
        send_str("HI");
        send_byte(CR);
        cr_cyc = rx_cyc_q[$];
        exp_q = {exp_q, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        total++;
        if (byte_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL hello_count: got %0d want %0d", byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (byte_q[i] !== exp_q[i]) begin bad++; $display("FAIL hello_byte[%0d]: got %02h want %02h", i, byte_q[i], exp_q[i]); end
            end
            f = exp_q.size() - 7;
`ifdef CHATBOT_ECHO_EN
            total++; if (load_cyc_q[0] !== rx_cyc_q[0] + 1) begin bad++; $display("FAIL echo_latency: got %0d want %0d", load_cyc_q[0], rx_cyc_q[0] + 1); end
            total++; if (load_cyc_q[f] !== done_cyc_q[f-1] + 2) begin bad++; $display("FAIL echo_to_resp: got %0d want %0d", load_cyc_q[f], done_cyc_q[f-1] + 2); end
`else
            total++; if (load_cyc_q[f] !== cr_cyc + 2) begin bad++; $display("FAIL cr_to_load: got %0d want %0d", load_cyc_q[f], cr_cyc + 2); end
`endif
            total++; if (load_cyc_q[f+1] !== done_cyc_q[f] + 1) begin bad++; $display("FAIL done_to_load: got %0d want %0d", load_cyc_q[f+1], done_cyc_q[f] + 1); end
            total++; if (busy_fall_cyc !== done_cyc_q[$] + 1) begin bad++; $display("FAIL busy_fall: got %0d want %0d", busy_fall_cyc, done_cyc_q[$] + 1); end
        end
        total++; if (bus.resp_code !== 2'd1) begin bad++; $display("FAIL hello_code: got %0d want 1", bus.resp_code); end
    endtask

    task automatic test_ping_hold();
        int f;
        clear_logs();
        hold_mode = 1'b1;
        send_str("PING");
        send_byte(CR);
        send_byte(LF);
        exp_q = {exp_q, 8'h50, 8'h4F, 8'h4E, 8'h47, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        repeat (30) @(posedge clk);
        #2;
        total++;
        if (byte_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL pong_count: got %0d want %0d", byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (byte_q[i] !== exp_q[i]) begin bad++; $display("FAIL pong_byte[%0d]: got %02h want %02h", i, byte_q[i], exp_q[i]); end
            end
            f = exp_q.size() - 6;
            total++; if (load_cyc_q[f+1] !== load_cyc_q[f] + 12) begin bad++; $display("FAIL level_no_event: got %0d want %0d", load_cyc_q[f+1], load_cyc_q[f] + 12); end
        end
        total++; if (bus.resp_code !== 2'd2) begin bad++; $display("FAIL pong_code: got %0d want 2", bus.resp_code); end
        hold_mode = 1'b0;
    endtask

    task automatic test_err();
        clear_logs();
        send_str("HX");
        send_byte(CR);
        exp_q = {exp_q, 8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        send_str("ABCDEFGHI");
        send_byte(CR);
        exp_q = {exp_q, 8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        total++;
        if (byte_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL err_count: got %0d want %0d", byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (byte_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_byte[%0d]: got %02h want %02h", i, byte_q[i], exp_q[i]); end
            end
        end
        total++; if (bus.resp_code !== 2'd3) begin bad++; $display("FAIL err_code: got %0d want 3", bus.resp_code); end
        clear_logs();
        send_byte(CR);
        repeat (40) @(posedge clk);
        #2;
        total++; if (byte_q.size() !== exp_q.size()) begin bad++; $display("FAIL empty_cr_loads: got %0d want %0d", byte_q.size(), exp_q.size()); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL empty_cr_busy: got %b want 0", bus.busy); end
        total++; if (bus.resp_code !== 2'd3) begin bad++; $display("FAIL empty_cr_code: got %0d want 3", bus.resp_code); end
    endtask

    task automatic test_busy_drop();
        int k;
        clear_logs();
        send_str("HI");
        send_byte(CR);
        exp_q = {exp_q, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
        k = 0;
        while (byte_q.size() < exp_q.size() - 5 && k < 1000) begin
            @(posedge clk); #2;
            k++;
        end
        total++; if (k >= 1000) begin bad++; $display("FAIL drop_wait: got %0d bytes want %0d", byte_q.size(), exp_q.size() - 5); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL drop_busy: got %b want 1", bus.busy); end
        send_byte("X");
        wait_resp(exp_q.size());
        send_str("HI");
        send_byte(CR);
        exp_q = {exp_q, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        total++;
        if (byte_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL drop_count: got %0d want %0d", byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (byte_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_byte[%0d]: got %02h want %02h", i, byte_q[i], exp_q[i]); end
            end
        end
        total++; if (bus.resp_code !== 2'd1) begin bad++; $display("FAIL drop_code: got %0d want 1", bus.resp_code); end
    endtask

    task automatic test_reset_mid();
        int base;
        int k;
        clear_logs();
        send_str("HI");
        send_byte(CR);
        base = exp_q.size();
        k = 0;
        while (byte_q.size() < base + 3 && k < 1000) begin
            @(posedge clk); #2;
            k++;
        end
        total++; if (k >= 1000) begin bad++; $display("FAIL mid_wait: got %0d bytes want %0d", byte_q.size(), base + 3); end
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.tx_load !== 1'b0) begin bad++; $display("FAIL mid_tx_load: got %b want 0", bus.tx_load); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.resp_code !== 2'd0) begin bad++; $display("FAIL mid_resp_code: got %0d want 0", bus.resp_code); end
        total++; if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL mid_tx_byte: got %02h want 00", bus.tx_byte); end
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        clear_logs();
        send_str("PING");
        send_byte(CR);
        exp_q = {exp_q, 8'h50, 8'h4F, 8'h4E, 8'h47, 8'h0D, 8'h0A};
        wait_resp(exp_q.size());
        total++;
        if (byte_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL after_reset_count: got %0d want %0d", byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (byte_q[i] !== exp_q[i]) begin bad++; $display("FAIL after_reset_byte[%0d]: got %02h want %02h", i, byte_q[i], exp_q[i]); end
            end
        end
        total++; if (bus.resp_code !== 2'd2) begin bad++; $display("FAIL after_reset_code: got %0d want 2", bus.resp_code); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_ping_hold();
        test_err();
        test_busy_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chatbot_responder.md
# chatbot_responder

Line-oriented command responder on the parallel side of the UART. Collects received bytes into a line buffer until carriage return, matches the line against a fixed command set, and streams the response string back one byte at a time through the UART transmit handshake. Sits between the UART receive/transmit parallel ports and the rest of the chatbot logic.

## Interface

Parameters:
- MAX_LEN, 8, line buffer depth in characters (1..15); longer lines are answered with ERR.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- rx_byte  input  8  received data, valid when rx_valid rises (UART Byte_Out).
- rx_valid  input  1  receive strobe (UART byte_has_been_received); rising edge = one new byte.
- tx_done  input  1  transmit complete level (UART byte_has_been_sent); rising edge = byte finished.
- tx_byte  output  8  byte to transmit (UART Byte_In); held stable from load until tx_done edge.
- tx_load  output  1  one-cycle transmit request (UART load).
- busy  output  1  high while responding or echoing; received bytes dropped.
- resp_code  output  2  last response issued: 0 none, 1 HELLO, 2 PONG, 3 ERR.

## Operation

- Edge detect: registered copies rx_valid_d, tx_done_d; rx_evt = rx_valid & ~rx_valid_d, done_evt = tx_done & ~tx_done_d.
- Commands, case-sensitive ASCII: "HI" -> "HELLO\r\n" (code 1); "PING" -> "PONG\r\n" (code 2); any other non-empty line -> "ERR\r\n" (code 3).
- LF (0x0A) always ignored. CR (0x0D) terminates the line; CR on empty line: no response, stays IDLE.
- Characters beyond MAX_LEN: not stored, overflow flag set; line answered ERR at CR.
- States:
  - IDLE: busy=0. rx_evt with printable byte -> store at buf[len], len+1 (or set overflow). rx_evt with CR and len>0 -> MATCH.
  - MATCH: compare len and buf against commands; latch resp_code; idx=0 -> LOAD.
  - LOAD: tx_byte=ROM[resp_code][idx], tx_load=1 for this cycle only -> WAIT.
  - WAIT: on done_evt: idx = last ? clear len/overflow -> IDLE : idx+1 -> LOAD.
- rx_evt in any state other than IDLE: byte discarded, buffer unchanged.
- Response ROM: 7, 6, 5 characters for codes 1, 2, 3; idx 3 bits.

## Timing

- Reset values: tx_byte=0x00, tx_load=0, busy=0, resp_code=0, len=0, overflow=0, state IDLE.
- CR rx_evt in cycle N: MATCH in N+1, first tx_load high in N+2.
- done_evt in cycle M: next tx_load in M+1; busy falls in M+1 after last character.
- busy high from MATCH entry until return to IDLE.
- tx_done already high on entry to WAIT produces no event; only a new rising edge advances.
- Reset mid-response: next cycle IDLE, tx_load=0, buffer cleared, resp_code=0; byte already in UART not aborted.
- Simultaneous rx_evt and done_evt in WAIT: done_evt processed, rx byte dropped.

## Configuration

- CHATBOT_ECHO_EN defined: every accepted rx_evt in IDLE (including CR and LF) first enters ECHO_LOAD (tx_byte=rx_byte, tx_load=1, busy=1) then ECHO_WAIT until done_evt; printable bytes are stored as usual; after echoing CR with len>0 -> MATCH, else IDLE. Echo of a byte issues tx_load at N+1 after rx_evt in N.
- Undefined: no echo states; only command responses are transmitted.

## Test plan

- "HI\r" with tx_done pulsed 20 cycles after each load -> tx_load sequence 0x48,0x45,0x4C,0x4C,0x4F,0x0D,0x0A; resp_code=1; busy returns 0.
- "PING\r\n" -> "PONG\r\n" (0x50,0x4F,0x4E,0x47,0x0D,0x0A), resp_code=2; trailing LF produces nothing.
- "HX\r" -> "ERR\r\n"; "ABCDEFGHI\r" (MAX_LEN=8) -> "ERR\r\n", resp_code=3; lone "\r" -> no tx_load.
- 'X' received during HELLO response -> busy=1, byte dropped; following "HI\r" answered HELLO exactly.
- reset asserted after third HELLO byte loaded -> next cycle tx_load=0, busy=0, resp_code=0; "PING\r" then answered PONG.
- CHATBOT_ECHO_EN: "HI\r" -> echoes 0x48,0x49,0x0D, each tx_load one cycle after rx_evt, then HELLO\r\n.
